fixin_decoder: RTL and testbench

- Receive-side inverse of the byte-duplicate/shift-fill encoder, which forms {din,din}, shifts it left by k=din[1:0]+1 and fills the low k bits with ones.
- Accepts 16-bit coded words over valid/ready and recovers the 8-bit byte.
- Flags invalid and ambiguous words and keeps saturating error statistics.
- Two-stage pipeline, full throughput, sits between the link capture logic and the byte consumer.

---
 rtl/fixin_decoder_if.sv | 23 ++
 rtl/fixin_decoder.sv | 140 ++++++++++++++
 tb/tb_fixin_decoder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fixin_decoder_if.sv
// Two valid/ready channels of the fixin decoder: coded words in, decoded bytes and flags out.
// The slave modport is the decoder's view; the master modport is the producer/consumer side.
interface fixin_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_shift;
  logic        out_err;
  logic        out_ambig;

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_data, out_shift, out_err, out_ambig
  );

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_data, out_shift, out_err, out_ambig
  );
endinterface

// File: rtl/fixin_decoder.sv
// Recovers a byte from a duplicate/shift-fill coded word. Two-stage valid/ready pipeline
// (capture, then registered decode) with saturating invalid/ambiguous word counters.
module fixin_decoder #(
  parameter int CNT_W    = 8,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  fixin_decoder_if.slave   bus,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] ambig_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [15:0]      s1_word_q, s1_word_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [2:0]       out_shift_q, out_shift_d;
  logic             out_err_q, out_err_d;
  logic             out_ambig_q, out_ambig_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] ambig_cnt_q, ambig_cnt_d;

  logic        s1_advance;
  logic        s1_move;
  logic [3:0]  match;
  logic [7:0]  dec_data;
  logic [2:0]  dec_shift;
  logic        dec_err;
  logic        dec_ambig;

  // Re-encode the candidate and compare; equivalent to checking fill, tag and wrap bits.
  function automatic logic k_match(input logic [15:0] w, input logic [7:0] d, input logic [3:0] k);
    logic [15:0] enc;
    enc = ({d, d} << k) | ((16'd1 << k) - 16'd1);
    return (enc == w) && (d[1:0] == 2'(k - 4'd1));
  endfunction

  assign s1_advance   = !out_valid_q || bus.out_ready;
  assign s1_move      = s1_valid_q && s1_advance;
  assign bus.in_ready = !s1_valid_q || s1_advance;

  always_comb begin
    match = {k_match(s1_word_q, s1_word_q[11:4], 4'd4),
             k_match(s1_word_q, s1_word_q[10:3], 4'd3),
             k_match(s1_word_q, s1_word_q[9:2],  4'd2),
             k_match(s1_word_q, s1_word_q[8:1],  4'd1)};
    dec_err   = (match == 4'b0000);
    dec_ambig = ((match & (match - 4'd1)) != 4'b0000);
    dec_data  = s1_word_q[15:8];
    dec_shift = 3'd0;
    if (match[3]) begin
      dec_data  = s1_word_q[11:4];
      dec_shift = 3'd4;
    end else if (match[2]) begin
      dec_data  = s1_word_q[10:3];
      dec_shift = 3'd3;
    end else if (match[1]) begin
      dec_data  = s1_word_q[9:2];
      dec_shift = 3'd2;
    end else if (match[0]) begin
      dec_data  = s1_word_q[8:1];
      dec_shift = 3'd1;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_word_d   = s1_word_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_shift_d = out_shift_q;
    out_err_d   = out_err_q;
    out_ambig_d = out_ambig_q;
    err_cnt_d   = err_cnt_q;
    ambig_cnt_d = ambig_cnt_q;

    if (bus.in_valid && bus.in_ready) begin
      s1_valid_d = 1'b1;
      s1_word_d  = bus.in_word;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    // Stage 2 only changes when it is free or being drained, which keeps held outputs stable.
    if (s1_advance) begin
      out_valid_d = s1_valid_q && !(DROP_ERR && dec_err);
      if (s1_valid_q) begin
        out_data_d  = dec_data;
        out_shift_d = dec_shift;
        out_err_d   = dec_err;
        out_ambig_d = dec_ambig;
      end
    end

    if (clr_counts) begin
      err_cnt_d   = '0;
      ambig_cnt_d = '0;
    end else if (s1_move) begin
      if (dec_err && (err_cnt_q != '1))
        err_cnt_d = err_cnt_q + CNT_W'(1);
      if (dec_ambig && (ambig_cnt_q != '1))
        ambig_cnt_d = ambig_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_word_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_shift_q <= '0;
      out_err_q   <= 1'b0;
      out_ambig_q <= 1'b0;
      err_cnt_q   <= '0;
      ambig_cnt_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_word_q   <= s1_word_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_shift_q <= out_shift_d;
      out_err_q   <= out_err_d;
      out_ambig_q <= out_ambig_d;
      err_cnt_q   <= err_cnt_d;
      ambig_cnt_q <= ambig_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_shift = out_shift_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_ambig = out_ambig_q;
  assign err_count     = err_cnt_q;
  assign ambig_count   = ambig_cnt_q;

endmodule

// File: tb/tb_fixin_decoder.sv
// Directed bench for fixin_decoder: default instance, a DROP_ERR=1 instance and a CNT_W=2
// instance all driven by the same stimulus.
module tb_fixin_decoder;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_word;
  logic        out_ready;
  logic        clr_counts;
  logic [7:0]  ec0, ac0, ec1, ac1;
  logic [1:0]  ec2, ac2;
  int          n_cmp;
  int          n_bad;

  fixin_decoder_if b0();
  fixin_decoder_if b1();
  fixin_decoder_if b2();

  assign b0.in_valid = in_valid;  assign b0.in_word = in_word;  assign b0.out_ready = out_ready;
  assign b1.in_valid = in_valid;  assign b1.in_word = in_word;  assign b1.out_ready = out_ready;
  assign b2.in_valid = in_valid;  assign b2.in_word = in_word;  assign b2.out_ready = out_ready;

  fixin_decoder u0 (.clk(clk), .rst(rst), .bus(b0), .clr_counts(clr_counts), .err_count(ec0), .ambig_count(ac0));
  fixin_decoder #(.DROP_ERR(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1), .clr_counts(clr_counts), .err_count(ec1), .ambig_count(ac1));
  fixin_decoder #(.CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(b2), .clr_counts(clr_counts), .err_count(ec2), .ambig_count(ac2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_word = 16'h0; out_ready = 1'b1; clr_counts = 1'b0;
    #12;
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", b0.out_valid); end
    n_cmp++; if (b0.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", b0.in_ready); end
    n_cmp++; if ({b0.out_data, b0.out_shift, b0.out_err, b0.out_ambig} !== 13'h0) begin n_bad++;
      $display("FAIL rst_outputs: got data %h shift %0d err %b ambig %b want all 0", b0.out_data, b0.out_shift, b0.out_err, b0.out_ambig); end
    n_cmp++; if ({ec0, ac0} !== 16'h0) begin n_bad++; $display("FAIL rst_counts: got %h/%h want 0/0", ec0, ac0); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (b0.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_in_ready: got %b want 1", b0.in_ready); end
  endtask

  task automatic test_unique();
    @(negedge clk); in_valid = 1'b1; in_word = 16'hBFBF;
    @(posedge clk); #1;
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_bad++; $display("FAIL uniq_early_valid: got %b want 0", b0.out_valid); end
    @(negedge clk); in_word = 16'hB8B9;
    @(posedge clk); #1;
    n_cmp++; if ({b0.out_valid, b0.out_data, b0.out_shift, b0.out_ambig, b0.out_err} !== {1'b1, 8'hFB, 3'd4, 1'b0, 1'b0}) begin n_bad++;
      $display("FAIL uniq_bfbf: got v%b d%h s%0d a%b e%b want v1 dfb s4 a0 e0", b0.out_valid, b0.out_data, b0.out_shift, b0.out_ambig, b0.out_err); end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({b0.out_valid, b0.out_data, b0.out_shift, b0.out_ambig, b0.out_err} !== {1'b1, 8'h5C, 3'd1, 1'b0, 1'b0}) begin n_bad++;
      $display("FAIL uniq_b8b9: got v%b d%h s%0d a%b e%b want v1 d5c s1 a0 e0", b0.out_valid, b0.out_data, b0.out_shift, b0.out_ambig, b0.out_err); end
    @(posedge clk); #1;
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_bad++; $display("FAIL uniq_drain: got %b want 0", b0.out_valid); end
  endtask

  task automatic test_ambig();
    @(negedge clk); in_valid = 1'b1; in_word = 16'h5557;
    @(posedge clk);
    @(negedge clk); in_word = 16'hB7B7;
    @(posedge clk); #1;
    n_cmp++; if ({b0.out_valid, b0.out_data, b0.out_shift, b0.out_ambig, b0.out_err} !== {1'b1, 8'hAA, 3'd3, 1'b1, 1'b0}) begin n_bad++;
      $display("FAIL ambig_5557: got v%b d%h s%0d a%b e%b want v1 daa s3 a1 e0", b0.out_valid, b0.out_data, b0.out_shift, b0.out_ambig, b0.out_err); end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({b0.out_valid, b0.out_data, b0.out_shift, b0.out_ambig, b0.out_err} !== {1'b1, 8'hF6, 3'd3, 1'b1, 1'b0}) begin n_bad++;
      $display("FAIL ambig_b7b7: got v%b d%h s%0d a%b e%b want v1 df6 s3 a1 e0", b0.out_valid, b0.out_data, b0.out_shift, b0.out_ambig, b0.out_err); end
    @(posedge clk); #1;
    n_cmp++; if ({ac0, ac1, 6'(ac2)} !== {8'd2, 8'd2, 6'd2}) begin n_bad++;
      $display("FAIL ambig_count: got %0d/%0d/%0d want 2/2/2", ac0, ac1, ac2); end
    n_cmp++; if (ec0 !== 8'd0) begin n_bad++; $display("FAIL ambig_err_count: got %0d want 0", ec0); end
  endtask

  task automatic test_invalid();
    @(negedge clk); in_valid = 1'b1; in_word = 16'h0000;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({b0.out_valid, b0.out_data, b0.out_shift, b0.out_err, b0.out_ambig} !== {1'b1, 8'h00, 3'd0, 1'b1, 1'b0}) begin n_bad++;
      $display("FAIL inv_out: got v%b d%h s%0d e%b a%b want v1 d00 s0 e1 a0", b0.out_valid, b0.out_data, b0.out_shift, b0.out_err, b0.out_ambig); end
    n_cmp++; if (b1.out_valid !== 1'b0) begin n_bad++; $display("FAIL inv_drop_valid: got %b want 0", b1.out_valid); end
    n_cmp++; if ({ec0, ec1} !== {8'd1, 8'd1}) begin n_bad++; $display("FAIL inv_err_count: got %0d/%0d want 1/1", ec0, ec1); end
    @(posedge clk); #1;
    n_cmp++; if ({b0.out_valid, b1.out_valid} !== 2'b00) begin n_bad++;
      $display("FAIL inv_drain: got %b%b want 00", b0.out_valid, b1.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'hFB; exp_d[1] = 8'h5C; exp_d[2] = 8'hAA; exp_d[3] = 8'hF6;
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_word = 16'hBFBF;
    @(posedge clk);
    @(negedge clk); in_word = 16'hB8B9;
    n_cmp++; if (b0.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_second_ready: got %b want 1", b0.in_ready); end
    @(posedge clk);
    @(negedge clk); in_word = 16'h5557;
    n_cmp++; if (b0.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %b want 0", b0.in_ready); end
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({b0.in_ready, b0.out_valid, b0.out_data} !== {1'b0, 1'b1, 8'hFB}) begin n_bad++;
      $display("FAIL bp_hold: got r%b v%b d%h want r0 v1 dfb", b0.in_ready, b0.out_valid, b0.out_data); end
    out_ready = 1'b1; #1;
    n_cmp++; if (b0.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_bubble_free: got %b want 1", b0.in_ready); end
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) begin
        in_word = 16'hB7B7;
        n_cmp++; if (b0.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_stream_ready: got %b want 1", b0.in_ready); end
      end
      if (c == 2) in_valid = 1'b0;
      n_cmp++; if ({b0.out_valid, b0.out_data} !== {1'b1, exp_d[c]}) begin n_bad++;
        $display("FAIL bp_order_%0d: got v%b d%h want v1 d%h", c, b0.out_valid, b0.out_data, exp_d[c]); end
    end
    @(negedge clk);
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup: got %b want 0", b0.out_valid); end
  endtask

  task automatic test_saturation();
    @(negedge clk); clr_counts = 1'b1;
    @(negedge clk); clr_counts = 1'b0;
    n_cmp++; if ({ec2, ac2} !== 4'h0) begin n_bad++; $display("FAIL sat_clear: got %0d/%0d want 0/0", ec2, ac2); end
    in_valid = 1'b1; in_word = 16'h0000;
    repeat (5) @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ec2 !== 2'd3) begin n_bad++; $display("FAIL sat_stick: got %0d want 3", ec2); end
    n_cmp++; if (ec0 !== 8'd5) begin n_bad++; $display("FAIL sat_wide_count: got %0d want 5", ec0); end
    @(negedge clk); in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0; clr_counts = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({ec2, ec0} !== 10'h0) begin n_bad++; $display("FAIL sat_clr_priority: got %0d/%0d want 0/0", ec2, ec0); end
    @(negedge clk); clr_counts = 1'b0;
  endtask

  task automatic test_reset_midstream();
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_word = 16'h5557;
    @(posedge clk);
    @(negedge clk); in_word = 16'h0000;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if ({b0.out_valid, b0.in_ready, ac0} !== {1'b1, 1'b0, 8'd1}) begin n_bad++;
      $display("FAIL mid_full: got v%b r%b ac%0d want v1 r0 ac1", b0.out_valid, b0.in_ready, ac0); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({b0.out_valid, b0.in_ready, ec0, ac0} !== {1'b0, 1'b1, 16'h0}) begin n_bad++;
      $display("FAIL mid_reset: got v%b r%b ec%0d ac%0d want v0 r1 ec0 ac0", b0.out_valid, b0.in_ready, ec0, ac0); end
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({b0.out_valid, b0.in_ready} !== 2'b01) begin n_bad++;
      $display("FAIL mid_release: got v%b r%b want v0 r1", b0.out_valid, b0.in_ready); end
    @(negedge clk);
    n_cmp++; if ({b0.out_valid, ec0} !== 9'h0) begin n_bad++;
      $display("FAIL mid_no_partial: got v%b ec%0d want v0 ec0", b0.out_valid, ec0); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_unique();
    test_ambig();
    test_invalid();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
